// File: rtl/rv32imc_types.sv
// ============================================================================
//  Module      : rv32imc_types (package)
//  Description : Shared types for the rv32imc data-memory path. Holds the
//                dmem responder state encoding and the latched request
//                record.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32imc_types;

  // Responder sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_rsp_state_t;

  // Request captured on accept. addr is a word address; only the low
  // SRAM_ADDR_W bits are meaningful for a given responder instance.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  // Width of the inline wait-state down-counter (supports 0..15 waits)
  localparam int unsigned DMEM_WCNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Responder end of the CPU data-memory port. Accepts
//                single-cycle read/write requests, optionally waits
//                WAIT_CYCLES cycles, performs one access on a synchronous
//                single-port SRAM and returns a one-cycle dmem_resp pulse
//                (latency WAIT_CYCLES+2 from the request cycle).
//  Ports       : clk, rst (sync, active-high)
//                dmem_addr/rmask/wmask/wdata -> request from memory stage
//                dmem_rdata/dmem_resp        -> completion to memory stage
//                sram_en/we/addr/wdata       -> SRAM macro controls
//                sram_rdata                  <- SRAM read data (1-cycle)
//                busy                        -> request outstanding
//                proto_err                   -> sticky protocol violation
//  Options     : `define DMEM_RESPONDER_PROTO_CHECK_EN enables the sticky
//                proto_err flag and simulation assertions; otherwise
//                proto_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import rv32imc_types::*;
#(
  parameter int unsigned SRAM_ADDR_W = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            dmem_addr,
  input  logic [3:0]             dmem_rmask,
  input  logic [3:0]             dmem_wmask,
  input  logic [31:0]            dmem_wdata,
  output logic [31:0]            dmem_rdata,
  output logic                   dmem_resp,
  output logic                   sram_en,
  output logic [3:0]             sram_we,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata,
  output logic                   busy,
  output logic                   proto_err
);

  // Counter preload on WAIT entry; unused when there are no wait states
  localparam logic [DMEM_WCNT_W-1:0] c_WAIT_LOAD =
    (WAIT_CYCLES > 0) ? DMEM_WCNT_W'(WAIT_CYCLES - 1) : '0;
  localparam dmem_rsp_state_t c_FIRST_STATE = (WAIT_CYCLES > 0) ? WAIT : ACCESS;

  dmem_rsp_state_t        state_q, state_d;
  logic [DMEM_WCNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t              req_q, req_d;

  logic w_req;
  logic w_both;
  logic w_violation;
  logic w_is_read;

  assign w_req  = |(dmem_rmask | dmem_wmask);
  assign w_both = (|dmem_rmask) && (|dmem_wmask);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    w_violation = 1'b0;
    case (state_q)
      // RESP accepts like IDLE so the CPU can chain requests with no bubble
      IDLE, RESP: begin
        if (w_req) begin
          req_d.addr  = 30'(dmem_addr[SRAM_ADDR_W+1:2]);
          req_d.rmask = dmem_rmask;
          req_d.wmask = dmem_wmask;
          req_d.wdata = dmem_wdata;
          state_d     = c_FIRST_STATE;
          cnt_d       = c_WAIT_LOAD;
          w_violation = w_both;
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Requests here are dropped without touching the latched one
        w_violation = w_req;
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACCESS: begin
        w_violation = w_req;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // A request with both masks set is treated as a write, so it returns 0
  assign w_is_read = (|req_q.rmask) && !(|req_q.wmask);

  assign dmem_resp  = (state_q == RESP);
  assign dmem_rdata = (dmem_resp && w_is_read) ? sram_rdata : 32'h0;
  // Decoded from the current state, so an ACCESS cycle that coincides with
  // rst still drives the SRAM; the reset takes effect on the next cycle.
  assign sram_en    = (state_q == ACCESS);
  assign sram_we    = sram_en ? req_q.wmask : 4'h0;
  assign sram_addr  = req_q.addr[SRAM_ADDR_W-1:0];
  assign sram_wdata = req_q.wdata;
  assign busy       = (state_q != IDLE);

`ifdef DMEM_RESPONDER_PROTO_CHECK_EN
  logic proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (w_violation) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;

`ifndef SYNTHESIS
  a_no_violation : assert property (@(posedge clk) disable iff (rst) !w_violation)
    else $error("dmem_responder: protocol violation (overlapping request or rmask&wmask both set)");
`endif
`else
  assign proto_err = 1'b0;

  logic w_unused_violation;
  assign w_unused_violation = w_violation;
`endif

  // Address bits outside the SRAM word range are intentionally ignored
  logic w_unused_addr;
  assign w_unused_addr = ^{dmem_addr[31:SRAM_ADDR_W+2], dmem_addr[1:0],
                           req_q.addr[29:SRAM_ADDR_W]};

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Three instances
//                (WAIT_CYCLES = 0, 1, 15) share one request stream, each
//                with its own SRAM model. A timestamp-based reference
//                model predicts every output each cycle; directed
//                sequences with literal expectations pin that model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int c_N = 3;
  localparam int c_W [c_N] = '{0, 1, 15};
`ifdef DMEM_RESPONDER_PROTO_CHECK_EN
  localparam logic c_PERR_ON_VIOL = 1'b1;
`else
  localparam logic c_PERR_ON_VIOL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        preload = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  rmask = '0;
  logic [3:0]  wmask = '0;

  logic [31:0] rdata_a  [c_N];
  logic        resp_a   [c_N];
  logic        en_a     [c_N];
  logic [3:0]  we_a     [c_N];
  logic [9:0]  saddr_a  [c_N];
  logic [31:0] swdata_a [c_N];
  logic        busy_a   [c_N];
  logic        perr_a   [c_N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar i = 0; i < c_N; i++) begin : g_dut
      logic [31:0] mem [1024];
      logic [31:0] srdata = '0;

      dmem_responder #(.SRAM_ADDR_W(10), .WAIT_CYCLES(c_W[i])) u_dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (addr),
        .dmem_rmask (rmask),
        .dmem_wmask (wmask),
        .dmem_wdata (wdata),
        .dmem_rdata (rdata_a[i]),
        .dmem_resp  (resp_a[i]),
        .sram_en    (en_a[i]),
        .sram_we    (we_a[i]),
        .sram_addr  (saddr_a[i]),
        .sram_wdata (swdata_a[i]),
        .sram_rdata (srdata),
        .busy       (busy_a[i]),
        .proto_err  (perr_a[i])
      );

      // Synchronous single-port SRAM: read data one cycle after en with we=0
      always @(posedge clk) begin
        if (preload) begin
          for (int j = 0; j < 1024; j++) mem[j] <= 32'h0;
          mem[16] <= 32'hDEADBEEF;
          mem[17] <= 32'h12345678;
        end else if (en_a[i]) begin
          if (we_a[i] == 4'h0) srdata <= mem[saddr_a[i]];
          for (int b = 0; b < 4; b++)
            if (we_a[i][b]) mem[saddr_a[i]][8*b +: 8] <= swdata_a[i][8*b +: 8];
        end
      end
    end
  endgenerate

  // ---------------- reference model (timestamp based) ----------------
  longint      cyc = 0;
  logic [31:0] ref_mem [c_N][1024];
  bit          m_valid [c_N];
  longint      m_resp  [c_N];
  logic [9:0]  m_addr  [c_N];
  logic [3:0]  m_wm    [c_N];
  logic [31:0] m_wd    [c_N];
  bit          m_rd    [c_N];
  bit          m_perr  [c_N];
  bit          m_prev_rst = 1'b0;

  always @(posedge clk) begin
    bit req, free, viol;
    if (preload) begin
      for (int k = 0; k < c_N; k++) begin
        for (int j = 0; j < 1024; j++) ref_mem[k][j] = 32'h0;
        ref_mem[k][16] = 32'hDEADBEEF;
        ref_mem[k][17] = 32'h12345678;
      end
    end
    for (int k = 0; k < c_N; k++) begin
      // The access cycle is the one just before the response cycle; a write
      // lands even if reset arrives in that same cycle.
      if (m_valid[k] && cyc == m_resp[k] - 1 && m_wm[k] != 4'h0)
        for (int b = 0; b < 4; b++)
          if (m_wm[k][b]) ref_mem[k][m_addr[k]][8*b +: 8] = m_wd[k][8*b +: 8];
      if (rst) begin
        m_valid[k] = 1'b0;
        m_perr[k]  = 1'b0;
      end else begin
        req  = (rmask | wmask) != 4'h0;
        free = !m_valid[k] || cyc == m_resp[k];
        viol = 1'b0;
        if (req && free) begin
          m_valid[k] = 1'b1;
          m_resp[k]  = cyc + c_W[k] + 2;
          m_addr[k]  = addr[11:2];
          m_wm[k]    = wmask;
          m_wd[k]    = wdata;
          m_rd[k]    = (wmask == 4'h0);
          viol       = (rmask != 4'h0) && (wmask != 4'h0);
        end else if (req) begin
          viol = 1'b1;
        end else if (m_valid[k] && cyc == m_resp[k]) begin
          m_valid[k] = 1'b0;
        end
        if (viol) m_perr[k] = 1'b1;
      end
    end
    m_prev_rst = rst;
    cyc++;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (WAIT_CYCLES=%0d) cycle %0d: got 0x%08h expected 0x%08h",
               nm, c_W[k], cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    logic e_resp, e_en;
    logic [31:0] e_rdata;
    for (int k = 0; k < c_N; k++) begin
      e_resp  = m_valid[k] && cyc == m_resp[k];
      e_en    = m_valid[k] && cyc == m_resp[k] - 1;
      e_rdata = (e_resp && m_rd[k]) ? ref_mem[k][m_addr[k]] : 32'h0;
      chk("m_resp", k, resp_a[k], e_resp);
      chk("m_busy", k, busy_a[k], m_valid[k]);
      chk("m_sram_en", k, en_a[k], e_en);
      chk("m_sram_we", k, we_a[k], e_en ? m_wm[k] : 4'h0);
      chk("m_rdata", k, rdata_a[k], e_rdata);
      chk("m_proto_err", k, perr_a[k], c_PERR_ON_VIOL & m_perr[k]);
      if (e_en) chk("m_sram_addr", k, saddr_a[k], m_addr[k]);
      if (e_en && m_wm[k] != 4'h0) chk("m_sram_wdata", k, swdata_a[k], m_wd[k]);
      if (m_prev_rst) begin
        chk("m_rst_addr", k, saddr_a[k], 32'h0);
        chk("m_rst_wdata", k, swdata_a[k], 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(negedge clk); endtask
  task automatic idle(); rmask = 4'h0; wmask = 4'h0; endtask
  task automatic drive(input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
    addr = a; rmask = rm; wmask = wm; wdata = wd;
  endtask
  task automatic gap(input int n); idle(); repeat (n) step(); endtask

  initial begin
    logic [31:0] a_rand;
    int unsigned r;

    step(); preload = 1'b0;
    step();
    for (int k = 0; k < c_N; k++) begin
      chk("rst_resp", k, resp_a[k], 32'h0);
      chk("rst_rdata", k, rdata_a[k], 32'h0);
      chk("rst_en", k, en_a[k], 32'h0);
      chk("rst_we", k, we_a[k], 32'h0);
      chk("rst_addr", k, saddr_a[k], 32'h0);
      chk("rst_wdata", k, swdata_a[k], 32'h0);
      chk("rst_busy", k, busy_a[k], 32'h0);
      chk("rst_perr", k, perr_a[k], 32'h0);
    end
    rst = 1'b0;

    // Read word 0x10
    step(); drive(32'h40, 4'hF, 4'h0, 32'h0);
    step(); idle();
    step(); chk("d1_en", 1, en_a[1], 1); chk("d1_addr", 1, saddr_a[1], 32'h10);
            chk("d1_noresp", 1, resp_a[1], 0);
    step(); chk("d1_resp", 1, resp_a[1], 1); chk("d1_rdata", 1, rdata_a[1], 32'hDEADBEEF);
    step(); chk("d1_once", 1, resp_a[1], 0);
    gap(20);

    // Byte write to lane 1, then read back
    drive(32'h41, 4'h0, 4'h2, 32'h0000AB00);
    step(); idle();
    step(); chk("d2_we", 1, we_a[1], 32'h2);
    step(); chk("d2_resp", 1, resp_a[1], 1); chk("d2_rdata", 1, rdata_a[1], 32'h0);
    gap(20);
    drive(32'h40, 4'hF, 4'h0, 32'h0);
    step(); idle();
    step();
    step(); chk("d2_readback", 1, rdata_a[1], 32'hDEADABEF);
    gap(20);

    // Back-to-back: second read issued in the response cycle
    drive(32'h40, 4'hF, 4'h0, 32'h0);
    step(); idle();
    step();
    step(); chk("d3_resp1", 1, resp_a[1], 1); chk("d3_busy", 1, busy_a[1], 1);
            drive(32'h44, 4'hF, 4'h0, 32'h0);
    step(); idle(); chk("d3_busy1", 1, busy_a[1], 1);
    step(); chk("d3_busy2", 1, busy_a[1], 1); chk("d3_en2", 1, en_a[1], 1);
    step(); chk("d3_resp2", 1, resp_a[1], 1); chk("d3_rdata2", 1, rdata_a[1], 32'h12345678);
    gap(20);

    // Request during WAIT is dropped
    drive(32'h40, 4'hF, 4'h0, 32'h0);
    step(); drive(32'h48, 4'h0, 4'hF, 32'hFFFFFFFF);
    step(); idle(); chk("d4_perr", 1, perr_a[1], c_PERR_ON_VIOL);
    step(); chk("d4_resp", 1, resp_a[1], 1); chk("d4_rdata", 1, rdata_a[1], 32'hDEADABEF);
    step(); chk("d4_noresp", 1, resp_a[1], 0); chk("d4_idle", 1, busy_a[1], 0);
    gap(20);
    drive(32'h48, 4'hF, 4'h0, 32'h0);
    step(); idle();
    step();
    step(); chk("d4_nowrite", 1, rdata_a[1], 32'h0);
    gap(20);

    // Reset during WAIT of a write (W=0 instance is in ACCESS then)
    drive(32'h4C, 4'h0, 4'hF, 32'hCAFEF00D);
    step(); idle(); rst = 1'b1;
    step();
    chk("d5_resp", 1, resp_a[1], 0); chk("d5_en", 1, en_a[1], 0);
    chk("d5_we", 1, we_a[1], 0);     chk("d5_addr", 1, saddr_a[1], 0);
    chk("d5_wdata", 1, swdata_a[1], 0); chk("d5_busy", 1, busy_a[1], 0);
    chk("d5_rdata", 1, rdata_a[1], 0);
    rst = 1'b0;
    step(); chk("d5_noresp1", 1, resp_a[1], 0);
    step(); chk("d5_noresp2", 1, resp_a[1], 0);
    gap(20);
    drive(32'h4C, 4'hF, 4'h0, 32'h0);
    step(); idle();
    step(); chk("d5_w0_written", 0, rdata_a[0], 32'hCAFEF00D);
    step(); chk("d5_w1_unwritten", 1, rdata_a[1], 32'h0);
    gap(20);

    // Latency boundaries: W=0 -> T+2, W=15 -> T+17
    drive(32'h40, 4'hF, 4'h0, 32'h0);
    for (int c = 1; c <= 18; c++) begin
      step(); idle();
      chk("d6_lat_w0", 0, resp_a[0], (c == 2) ? 1 : 0);
      chk("d6_lat_w15", 2, resp_a[2], (c == 17) ? 1 : 0);
      if (c == 17) chk("d6_rdata_w15", 2, rdata_a[2], 32'hDEADABEF);
    end
    gap(5);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      a_rand = $urandom();
      addr   = {a_rand[31:12], 5'b0, a_rand[6:0]};
      wdata  = $urandom();
      r      = $urandom_range(0, 99);
      if (r < 45) begin
        idle();
      end else if (r < 70) begin
        rmask = 4'($urandom_range(1, 15)); wmask = 4'h0;
      end else if (r < 93) begin
        rmask = 4'h0; wmask = 4'($urandom_range(1, 15));
      end else begin
        rmask = 4'($urandom_range(1, 15)); wmask = 4'($urandom_range(1, 15));
      end
      step();
    end
    rst = 1'b0;
    gap(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
